// File: rtl/ts_sync_detector_pkg.sv
// Shared constants and types for the MPEG-TS sync detector: parameter defaults,
// error-counter saturation limit and the acquisition FSM encoding.
package ts_sync_detector_pkg;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'h47;
  localparam int unsigned DEF_PKT_LEN   = 188;
  localparam int unsigned DEF_LOCK_N    = 3;
  localparam int unsigned DEF_UNLOCK_N  = 3;
  localparam logic [15:0] COUNTER_LIMIT = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  // 3-bit increment that sticks at 7 instead of wrapping
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/ts_sync_detector.sv
// MPEG-TS sync acquisition: hunts for the sync byte, verifies it on LOCK_N
// consecutive packet boundaries, then tracks lock and counts missed syncs.
module ts_sync_detector
  import ts_sync_detector_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int unsigned PKT_LEN   = DEF_PKT_LEN,
  parameter int unsigned LOCK_N    = DEF_LOCK_N,
  parameter int unsigned UNLOCK_N  = DEF_UNLOCK_N
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA,
  input  logic        DVALID,
  input  logic        CLR_ERR,
  output logic        LOCK,
  output logic        PKT_START,
  output logic        SYNC_ERR,
  output logic [15:0] ERR_COUNT
);

  localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);
  localparam logic [2:0] LOCK_TH   = 3'(LOCK_N);
  localparam logic [2:0] UNLOCK_TH = 3'(UNLOCK_N);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_idx, w_idx_nxt, w_idx_adv;
  logic [2:0]  r_good, w_good_nxt, w_good_inc;
  logic [2:0]  r_miss, w_miss_nxt, w_miss_inc;
  logic        r_lock, r_pkt_start, r_sync_err;
  logic        w_pkt_start, w_sync_err;
  logic [15:0] r_err_cnt;
  logic        w_is_sync, w_at_zero;

  assign w_is_sync  = (DATA == SYNC_BYTE);
  assign w_at_zero  = (r_idx == '0);
  assign w_idx_adv  = (r_idx == LAST_IDX) ? '0 : r_idx + 8'd1;
  assign w_good_inc = sat_inc3(r_good);
  assign w_miss_inc = sat_inc3(r_miss);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= HUNT;
      r_idx       <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_lock      <= 1'b0;
      r_pkt_start <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_good      <= w_good_nxt;
      r_miss      <= w_miss_nxt;
      r_lock      <= (w_state_nxt == LOCKED);
      r_pkt_start <= w_pkt_start;
      r_sync_err  <= w_sync_err;
    end
  end

  // HUNT parks the index at 0, so the advanced index on a hit is already 1
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_pkt_start = 1'b0;
    w_sync_err  = 1'b0;
    if (DVALID) begin
      w_idx_nxt = w_idx_adv;
      case (r_state)
        HUNT: begin
          if (w_is_sync) begin
            w_good_nxt  = 3'd1;
            w_state_nxt = (LOCK_TH <= 3'd1) ? LOCKED : VERIFY;
          end else begin
            w_idx_nxt = '0;
          end
        end
        VERIFY: begin
          if (w_at_zero) begin
            if (w_is_sync) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc >= LOCK_TH) begin
                w_state_nxt = LOCKED;
                w_miss_nxt  = '0;
              end
            end else begin
              w_state_nxt = HUNT;
              w_good_nxt  = '0;
              w_idx_nxt   = '0;
            end
          end
        end
        LOCKED: begin
          if (w_at_zero) begin
            if (w_is_sync) begin
              w_miss_nxt  = '0;
              w_pkt_start = 1'b1;
            end else begin
              w_miss_nxt = w_miss_inc;
              w_sync_err = 1'b1;
              if (w_miss_inc >= UNLOCK_TH) begin
                w_state_nxt = HUNT;
                w_miss_nxt  = '0;
                w_good_nxt  = '0;
                w_idx_nxt   = '0;
              end
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_idx_nxt   = '0;
          w_good_nxt  = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle miss
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_cnt <= '0;
    end else if (CLR_ERR) begin
      r_err_cnt <= '0;
    end else if (w_sync_err && (r_err_cnt != COUNTER_LIMIT)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign LOCK      = r_lock;
  assign PKT_START = r_pkt_start;
  assign SYNC_ERR  = r_sync_err;
  assign ERR_COUNT = r_err_cnt;

endmodule

// File: tb/tb_ts_sync_detector.sv
// Scenario bench for ts_sync_detector: expected pulse events are queued as each
// packet is sent and matched against pulses observed after each clock.
module tb_ts_sync_detector;

  localparam int unsigned PKT = 188;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA = 8'h00;
  logic        DVALID = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        LOCK, PKT_START, SYNC_ERR;
  logic [15:0] ERR_COUNT;

  typedef struct packed {
    logic        kind;   // 1 = PKT_START, 0 = SYNC_ERR
    logic [31:0] at;     // byte_no of the qualifying byte
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int unsigned byte_no  = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ts_sync_detector #(
    .SYNC_BYTE(8'h47),
    .PKT_LEN  (188),
    .LOCK_N   (3),
    .UNLOCK_N (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA     (DATA),
    .DVALID   (DVALID),
    .CLR_ERR  (CLR_ERR),
    .LOCK     (LOCK),
    .PKT_START(PKT_START),
    .SYNC_ERR (SYNC_ERR),
    .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic clr);
    DATA    = d;
    DVALID  = v;
    CLR_ERR = clr;
    @(posedge CLK);
    #1;
    byte_no++;
    if (PKT_START) obs_q.push_back('{1'b1, byte_no});
    if (SYNC_ERR)  obs_q.push_back('{1'b0, byte_no});
    CLR_ERR = 1'b0;
    DVALID  = 1'b0;
  endtask

  // One packet: first byte `sync`, then PKT-1 bytes of `fill`; `gap` idle cycles
  // (DATA=0x47, DVALID=0) follow every valid byte. lk = LOCK right after the first byte.
  task automatic send_pkt(input logic [7:0] sync, input logic [7:0] fill,
                          input int unsigned gap, output logic lk);
    drive(sync, 1'b1, 1'b0);
    lk = LOCK;
    repeat (gap) drive(8'h47, 1'b0, 1'b0);
    for (int unsigned i = 1; i < PKT; i++) begin
      drive(fill, 1'b1, 1'b0);
      repeat (gap) drive(8'h47, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b want 0", LOCK); end
    n_checks++; if (PKT_START !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_start: got %b want 0", PKT_START); end
    n_checks++; if (SYNC_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_sync_err: got %b want 0", SYNC_ERR); end
    n_checks++; if (ERR_COUNT !== 16'h0000) begin n_fail++; $display("FAIL rst_err_count: got %h want 0000", ERR_COUNT); end
    RST = 1'b0;
  endtask

  task automatic test_clean_lock();
    logic lk;
    ev_t  e, o;
    for (int unsigned k = 1; k <= 5; k++) begin
      if (k >= 4) exp_q.push_back('{1'b1, byte_no + 1});
      send_pkt(8'h47, 8'h00, 0, lk);
      n_checks++;
      if (lk !== (k >= 3)) begin n_fail++; $display("FAIL clean_lock_%0d: got %b want %b", k, lk, (k >= 3)); end
    end
    n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL clean_err: got %0d want 0", ERR_COUNT); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL clean_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL clean_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL clean_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  task automatic test_miss_recover();
    logic lk;
    ev_t  e, o;
    for (int unsigned r = 0; r < 2; r++) begin
      exp_q.push_back('{1'b0, byte_no + 1});
      send_pkt(8'h00, 8'h00, 0, lk);
      exp_q.push_back('{1'b0, byte_no + 1});
      send_pkt(8'h00, 8'h00, 0, lk);
      exp_q.push_back('{1'b1, byte_no + 1});
      send_pkt(8'h47, 8'h00, 0, lk);
      n_checks++; if (lk !== 1'b1) begin n_fail++; $display("FAIL miss_lock_%0d: got %b want 1", r, lk); end
      n_checks++;
      if (ERR_COUNT !== 16'(2 * (r + 1))) begin n_fail++; $display("FAIL miss_err_%0d: got %0d want %0d", r, ERR_COUNT, 2 * (r + 1)); end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL miss_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL miss_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL miss_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  task automatic test_unlock();
    logic lk;
    ev_t  e, o;
    drive(8'h00, 1'b0, 1'b1);
    n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL unlock_clr: got %0d want 0", ERR_COUNT); end
    for (int unsigned k = 1; k <= 3; k++) begin
      exp_q.push_back('{1'b0, byte_no + 1});
      send_pkt(8'h00, 8'h00, 0, lk);
      n_checks++;
      if (lk !== (k < 3)) begin n_fail++; $display("FAIL unlock_lock_%0d: got %b want %b", k, lk, (k < 3)); end
    end
    n_checks++; if (ERR_COUNT !== 16'd3) begin n_fail++; $display("FAIL unlock_err: got %0d want 3", ERR_COUNT); end
    // back in HUNT: three fresh syncs needed, no pulses meanwhile
    for (int unsigned k = 1; k <= 3; k++) begin
      send_pkt(8'h47, 8'h00, 0, lk);
      n_checks++;
      if (lk !== (k == 3)) begin n_fail++; $display("FAIL unlock_reacq_%0d: got %b want %b", k, lk, (k == 3)); end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL unlock_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL unlock_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL unlock_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  task automatic test_err_saturation();
    logic lk;
    ev_t  e, o;
    force dut.r_err_cnt = 16'hFFFF;
    #1;
    release dut.r_err_cnt;
    n_checks++; if (ERR_COUNT !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preload: got %h want ffff", ERR_COUNT); end
    exp_q.push_back('{1'b0, byte_no + 1});
    send_pkt(8'h00, 8'h00, 0, lk);
    n_checks++; if (ERR_COUNT !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", ERR_COUNT); end
    exp_q.push_back('{1'b0, byte_no + 1});
    drive(8'h00, 1'b1, 1'b1);
    n_checks++; if (ERR_COUNT !== 16'h0000) begin n_fail++; $display("FAIL sat_clr_miss: got %h want 0000", ERR_COUNT); end
    for (int unsigned i = 1; i < PKT; i++) drive(8'h00, 1'b1, 1'b0);
    exp_q.push_back('{1'b1, byte_no + 1});
    send_pkt(8'h47, 8'h00, 0, lk);
    n_checks++; if (lk !== 1'b1) begin n_fail++; $display("FAIL sat_lock: got %b want 1", lk); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL sat_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL sat_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL sat_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  task automatic test_reset_locked();
    logic lk;
    ev_t  e, o;
    exp_q.push_back('{1'b0, byte_no + 1});
    drive(8'h00, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 50; i++) drive(8'h00, 1'b1, 1'b0);
    n_checks++; if (LOCK !== 1'b1 || ERR_COUNT !== 16'd1) begin n_fail++; $display("FAIL rstlk_pre: got lock=%b err=%0d want lock=1 err=1", LOCK, ERR_COUNT); end
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL rstlk_lock: got %b want 0", LOCK); end
    n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL rstlk_err: got %0d want 0", ERR_COUNT); end
    n_checks++; if (PKT_START !== 1'b0 || SYNC_ERR !== 1'b0) begin n_fail++; $display("FAIL rstlk_pulses: got %b%b want 00", PKT_START, SYNC_ERR); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int unsigned i = 0; i < 30; i++) drive(8'h00, 1'b1, 1'b0);
    for (int unsigned k = 1; k <= 3; k++) begin
      send_pkt(8'h47, 8'h00, 0, lk);
      n_checks++;
      if (lk !== (k == 3)) begin n_fail++; $display("FAIL rstlk_reacq_%0d: got %b want %b", k, lk, (k == 3)); end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rstlk_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rstlk_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstlk_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  task automatic test_verify_fail();
    logic lk;
    ev_t  e, o;
    do_reset();
    send_pkt(8'h47, 8'h47, 0, lk);
    n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL vfy_first: got %b want 0", lk); end
    send_pkt(8'h00, 8'h00, 0, lk);
    n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL vfy_corrupt: got %b want 0", lk); end
    for (int unsigned i = 0; i < 10; i++) drive(8'h00, 1'b1, 1'b0);
    for (int unsigned k = 1; k <= 3; k++) begin
      send_pkt(8'h47, 8'h00, 0, lk);
      n_checks++;
      if (lk !== (k == 3)) begin n_fail++; $display("FAIL vfy_restart_%0d: got %b want %b", k, lk, (k == 3)); end
    end
    exp_q.push_back('{1'b1, byte_no + 1});
    send_pkt(8'h47, 8'h47, 0, lk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL vfy_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL vfy_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL vfy_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  task automatic test_dvalid_gaps();
    logic lk;
    ev_t  e, o;
    do_reset();
    for (int unsigned k = 1; k <= 3; k++) begin
      send_pkt(8'h47, 8'h00, 1, lk);
      n_checks++;
      if (lk !== (k == 3)) begin n_fail++; $display("FAIL gap_lock_%0d: got %b want %b", k, lk, (k == 3)); end
    end
    exp_q.push_back('{1'b1, byte_no + 1});
    send_pkt(8'h47, 8'h00, 1, lk);
    n_checks++; if (LOCK !== 1'b1 || ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL gap_end: got lock=%b err=%0d want lock=1 err=0", LOCK, ERR_COUNT); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL gap_ev: missing kind=%0d at byte %0d", e.kind, e.at); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL gap_ev: got kind=%0d@%0d want kind=%0d@%0d", o.kind, o.at, e.kind, e.at); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL gap_extra: %0d unexpected pulses, first kind=%0d@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].at); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_miss_recover();
    test_unlock();
    test_err_saturation();
    test_reset_locked();
    test_verify_fail();
    test_dvalid_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_sync_detector.md
TS_SYNC_DETECTOR -- requirements
Module: ts_sync_detector

Interface
REQ-001 The parameter SYNC_BYTE SHALL default to 8'h47 and be the MPEG-TS sync byte value.
REQ-002 The parameter PKT_LEN SHALL default to 188 and be the packet length in bytes.
REQ-003 The parameter LOCK_N SHALL default to 3 and be the count of consecutive correct syncs required to declare lock.
REQ-004 The parameter UNLOCK_N SHALL default to 3 and be the count of consecutive missed syncs required to drop lock.
REQ-005 CLK SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-006 RST SHALL be an input, 1 bit wide: reset, asynchronous, active-high.
REQ-007 DATA SHALL be an input, 8 bits wide: the TS byte stream.
REQ-008 DVALID SHALL be an input, 1 bit wide: DATA qualifier; one byte is consumed per cycle while high.
REQ-009 CLR_ERR SHALL be an input, 1 bit wide: a synchronous clear pulse for ERR_COUNT.
REQ-010 LOCK SHALL be an output, 1 bit wide: the sync-lock status (feeds the LED stretcher).
REQ-011 PKT_START SHALL be an output, 1 bit wide: a one-cycle pulse on each accepted sync byte while locked.
REQ-012 SYNC_ERR SHALL be an output, 1 bit wide: a one-cycle pulse on each missed sync while locked.
REQ-013 ERR_COUNT SHALL be an output, 16 bits wide: a saturating count of missed syncs.

Function
REQ-014 The FSM SHALL have exactly three states: HUNT, VERIFY, LOCKED.
REQ-015 The 8-bit byte index SHALL advance only on cycles with DVALID=1, wrapping from PKT_LEN-1 to 0; index 0 is the expected sync position.
REQ-016 Cycles with DVALID=0 SHALL change no state, counter or output, except that pulse outputs return to 0.
REQ-017 In HUNT, a valid byte equal to SYNC_BYTE SHALL set index to 1 and good_cnt to 1, and move the FSM to VERIFY; any other valid byte SHALL be ignored.
REQ-018 In VERIFY, at index 0 a valid SYNC_BYTE SHALL increment good_cnt; when good_cnt reaches LOCK_N the FSM SHALL enter LOCKED and LOCK SHALL be 1 from the next cycle.
REQ-019 In VERIFY, at index 0 a valid non-sync byte SHALL return the FSM to HUNT with good_cnt=0; that same byte SHALL NOT be re-examined as a sync candidate.
REQ-020 In LOCKED, at index 0 a valid SYNC_BYTE SHALL clear miss_cnt and pulse PKT_START for one cycle.
REQ-021 In LOCKED, at index 0 a valid non-sync byte SHALL increment miss_cnt, pulse SYNC_ERR, and increment ERR_COUNT.
REQ-022 When miss_cnt reaches UNLOCK_N the FSM SHALL enter HUNT and LOCK SHALL be 0 from the next cycle.
REQ-023 The byte index SHALL keep running in LOCKED across missed syncs; there is no realignment until HUNT.
REQ-024 Sync bytes at index other than 0 SHALL be treated as payload in VERIFY and LOCKED.
REQ-025 All outputs SHALL be registered; pulse latency SHALL be 1 cycle after the qualifying byte.
REQ-026 ERR_COUNT SHALL saturate at 16'hFFFF.
REQ-027 CLR_ERR SHALL clear ERR_COUNT to 0 and SHALL take priority over a simultaneous increment, giving a result of 0.
REQ-028 good_cnt and miss_cnt SHALL be 3 bits wide and SHALL never wrap.

Reset
REQ-029 RST=1 SHALL asynchronously force the FSM to HUNT, all counters to 0, and LOCK, PKT_START, SYNC_ERR and ERR_COUNT to 0.
REQ-030 Reset asserted mid-packet or while LOCKED SHALL discard all alignment; after release, acquisition SHALL restart from HUNT.

Structure
REQ-031 SYNC_BYTE, PKT_LEN, LOCK_N and UNLOCK_N defaults SHALL reside in the shared defines include file beside COUNTER_LIMIT.
REQ-032 The block SHALL be a single module with no sub-modules; the saturating error counter MAY be an inline always block.

Verification
REQ-033 Clean stream of 5 packets (0x47 + 187 bytes 0x00, DVALID=1 continuous) -> LOCK rises the cycle after the 3rd sync byte; PKT_START pulses on the 4th and 5th syncs.
REQ-034 Locked stream with 2 corrupted syncs (0x00) followed by a good sync -> 2 SYNC_ERR pulses; ERR_COUNT=2; LOCK stays 1; miss_cnt is cleared by the good sync.
REQ-035 Locked stream with 3 consecutive corrupted syncs -> LOCK falls the cycle after the 3rd; ERR_COUNT=3; FSM in HUNT.
REQ-036 VERIFY with the 2nd sync corrupted -> FSM back to HUNT; LOCK remains 0; a later stray 0x47 restarts VERIFY.
REQ-037 DVALID toggling 1/0 every cycle on a clean stream -> lock is acquired after 3 packets of valid bytes, with timing scaled by the gaps.
REQ-038 ERR_COUNT preloaded to 16'hFFFF plus another miss -> ERR_COUNT stays 16'hFFFF; CLR_ERR coinciding with a miss -> ERR_COUNT=0; RST pulse while LOCKED -> all outputs 0 immediately.
